soc_system_ocram_stream_writer: RTL

- Avalon-ST sink to Avalon-MM write master that fills the 64-bit, 8192-word on-chip RAM from a 32-bit stream.
- Packs pairs of 32-bit beats into 64-bit words with byte enables, bounded by a programmed base address and word limit.
- Sits directly upstream of the OCRAM s1 port. HPS software reads the filled buffer via s2.

---
 rtl/soc_system_ocram_wr_pkg.sv | 20 ++
 rtl/soc_system_ocram_wr_packer.sv | 38 +++
 rtl/soc_system_ocram_stream_writer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/soc_system_ocram_wr_pkg.sv
// rtl/soc_system_ocram_wr_pkg.sv - shared widths, byte enables and FSM states for the OCRAM stream writer
package soc_system_ocram_wr_pkg;

  localparam int DEF_ADDR_W = 13;
  localparam int DEF_IN_W   = 32;
  localparam int DEF_MEM_W  = 64;
  localparam int DEF_CNT_W  = 14;

  localparam logic [7:0] BE_FULL = 8'hFF;
  localparam logic [7:0] BE_LOW  = 8'h0F;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LO     = 3'd1,
    HI     = 3'd2,
    FIN    = 3'd3,
    DONE_P = 3'd4
  } state_e;

endpackage

// File: rtl/soc_system_ocram_wr_packer.sv
// rtl/soc_system_ocram_wr_packer.sv - holds the low half-word and forms the 64-bit write word and byte enables
module soc_system_ocram_wr_packer
  import soc_system_ocram_wr_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int MEM_W = DEF_MEM_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             lo_load,
  input  logic             half_hi,
  input  logic [IN_W-1:0]  beat_data,
  output logic [MEM_W-1:0] wdata,
  output logic [7:0]       byteenable
);

  logic [IN_W-1:0] lo_q;
  logic [IN_W-1:0] lo_d;

  assign lo_d = lo_load ? beat_data : lo_q;

  always_ff @(posedge clk) begin
    if (!reset_n) lo_q <= '0;
    else          lo_q <= lo_d;
  end

  // Earlier beat lands in the lower address bytes.
  always_comb begin
    if (half_hi) begin
      wdata      = {beat_data, lo_q};
      byteenable = BE_FULL;
    end else begin
      wdata      = {{(MEM_W-IN_W){1'b0}}, beat_data};
      byteenable = BE_LOW;
    end
  end

endmodule

// File: rtl/soc_system_ocram_stream_writer.sv
// rtl/soc_system_ocram_stream_writer.sv - 32-bit stream sink packing beat pairs into 64-bit OCRAM writes
// Optional stall counter enabled by defining OCRAM_WR_STALL_CNT_EN.
module soc_system_ocram_stream_writer
  import soc_system_ocram_wr_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int IN_W   = DEF_IN_W,
  parameter int MEM_W  = DEF_MEM_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_address,
  input  logic [CNT_W-1:0]  max_words,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [CNT_W-1:0]  words_written,
  output logic [31:0]       stall_cycles,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_eop,
  output logic [ADDR_W-1:0] mem_address,
  output logic [7:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [MEM_W-1:0]  mem_writedata,
  output logic              mem_clken
);

  state_e state_q, state_d;

  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  limit_q, limit_d;
  logic [CNT_W-1:0]  words_q, words_d;
  logic              ovf_q, ovf_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [MEM_W-1:0]  wdata_q, wdata_d;
  logic [7:0]        be_q, be_d;

  logic [MEM_W-1:0]  pk_wdata;
  logic [7:0]        pk_be;
  logic [CNT_W-1:0]  words_inc;
  logic              accept, start_acc, issue, limit_hit;

  assign words_inc = words_q + CNT_W'(1);
  assign accept    = in_valid & in_ready;
  assign start_acc = (state_q == IDLE) & start;
  assign issue     = accept & ((state_q == HI) | in_eop);
  assign limit_hit = accept & (state_q == HI) & ~in_eop & (words_inc == limit_q);

  soc_system_ocram_wr_packer #(
    .IN_W  (IN_W),
    .MEM_W (MEM_W)
  ) u_packer (
    .clk        (clk),
    .reset_n    (reset_n),
    .lo_load    (accept & (state_q == LO)),
    .half_hi    (state_q == HI),
    .beat_data  (in_data),
    .wdata      (pk_wdata),
    .byteenable (pk_be)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (max_words == '0) ? DONE_P : LO;
      LO:      if (accept) state_d = in_eop ? FIN : HI;
      HI:      if (accept) state_d = (in_eop || (words_inc == limit_q)) ? FIN : LO;
      FIN:     state_d = DONE_P;
      DONE_P:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == LO) || (state_q == HI);
    busy     = (state_q == LO) || (state_q == HI) || (state_q == FIN);
    done     = (state_q == DONE_P);
  end

  // The write is registered, so it commits the cycle after its completing beat.
  always_comb begin
    base_d  = base_q;
    limit_d = limit_q;
    words_d = words_q;
    ovf_d   = ovf_q;
    wr_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    if (start_acc) begin
      base_d  = base_address;
      limit_d = max_words;
      words_d = '0;
      ovf_d   = 1'b0;
    end
    if (issue) begin
      wr_d    = 1'b1;
      addr_d  = base_q + words_q[ADDR_W-1:0];
      wdata_d = pk_wdata;
      be_d    = pk_be;
      words_d = words_inc;
    end
    if (limit_hit) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      base_q  <= '0;
      limit_q <= '0;
      words_q <= '0;
      ovf_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      base_q  <= base_d;
      limit_q <= limit_d;
      words_q <= words_d;
      ovf_q   <= ovf_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  assign overflow       = ovf_q;
  assign words_written  = words_q;
  assign mem_write      = wr_q;
  assign mem_chipselect = wr_q;
  assign mem_address    = addr_q;
  assign mem_writedata  = wdata_q;
  assign mem_byteenable = be_q;
  assign mem_clken      = 1'b1;

`ifdef OCRAM_WR_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (start_acc)                                  stall_d = '0;
    else if (in_ready && !in_valid && stall_q != '1) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) stall_q <= '0;
    else          stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule
